// File: rtl/multi_sram_arb.sv
// Two-port (A = loader, B = compute) front end over NUM_BANKS single-port SRAM banks.
// Per-bank round-robin on same-bank conflicts; reads return READ_LAT cycles after accept.
module multi_sram_arb #(
  parameter int NUM_BANKS  = 4,
  parameter int DEPTH      = 256,
  parameter int DATA_W     = 8,
  parameter int READ_LAT   = 1,
  parameter int INTERLEAVE = 0,
  parameter int ADDR_W     = $clog2(NUM_BANKS * DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata
);
  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int ENTRY_W = $clog2(DEPTH);

  // Index 0 is port A, index 1 is port B throughout.
  logic [1:0]               req_vld;
  logic [1:0]               req_we;
  logic [1:0]               req_rdy;
  logic [1:0]               acc;
  logic [1:0][ADDR_W-1:0]   req_addr;
  logic [1:0][DATA_W-1:0]   req_wdat;
  logic [1:0][BANK_W-1:0]   bank;
  logic [1:0][ENTRY_W-1:0]  entry;
  logic                     conflict;
  logic [NUM_BANKS-1:0]     prio_q, prio_d;
  logic [1:0]               rvld1_q, rvld1_d;
  logic [1:0][DATA_W-1:0]   rdat1_q, rdat1_d;
  logic [1:0]               rvld_out;
  logic [1:0][DATA_W-1:0]   rdat_out;
  logic [DATA_W-1:0]        mem [NUM_BANKS][DEPTH];

  assign req_vld  = {b_valid, a_valid};
  assign req_we   = {b_we, a_we};
  assign req_addr = {b_addr, a_addr};
  assign req_wdat = {b_wdata, a_wdata};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      if (INTERLEAVE != 0) begin
        bank[p]  = req_addr[p][BANK_W-1:0];
        entry[p] = req_addr[p][ADDR_W-1:BANK_W];
      end else begin
        bank[p]  = req_addr[p][ADDR_W-1 -: BANK_W];
        entry[p] = req_addr[p][ENTRY_W-1:0];
      end
    end
  end

  // A conflict stalls the port the bank's prio bit does not point at.
  always_comb begin
    conflict   = req_vld[0] & req_vld[1] & (bank[0] == bank[1]);
    req_rdy[0] = ~rst & ~(conflict &  prio_q[bank[0]]);
    req_rdy[1] = ~rst & ~(conflict & ~prio_q[bank[1]]);
    acc        = req_vld & req_rdy;
    prio_d     = prio_q;
    if (conflict) begin
      prio_d[bank[0]] = ~prio_q[bank[0]];
    end
    for (int p = 0; p < 2; p++) begin
      rvld1_d[p] = acc[p] & ~req_we[p];
      rdat1_d[p] = rvld1_d[p] ? mem[bank[p]][entry[p]] : rdat1_q[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q  <= '0;
      rvld1_q <= '0;
      rdat1_q <= '0;
    end else begin
      prio_q  <= prio_d;
      rvld1_q <= rvld1_d;
      rdat1_q <= rdat1_d;
    end
  end

  // Bank storage carries no reset; accepted ports never share a bank in one cycle.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (acc[p] & req_we[p]) begin
        mem[bank[p]][entry[p]] <= req_wdat[p];
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [1:0]             rvld2_q, rvld2_d;
      logic [1:0][DATA_W-1:0] rdat2_q, rdat2_d;

      always_comb begin
        rvld2_d = rvld1_q;
        for (int p = 0; p < 2; p++) begin
          rdat2_d[p] = rvld1_q[p] ? rdat1_q[p] : rdat2_q[p];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rvld2_q <= '0;
          rdat2_q <= '0;
        end else begin
          rvld2_q <= rvld2_d;
          rdat2_q <= rdat2_d;
        end
      end

      assign rvld_out = rvld2_q;
      assign rdat_out = rdat2_q;
    end else begin : g_lat1
      assign rvld_out = rvld1_q;
      assign rdat_out = rdat1_q;
    end
  endgenerate

  // Masking with rst drops a return that would land in the reset cycle itself.
  assign a_ready  = req_rdy[0];
  assign b_ready  = req_rdy[1];
  assign a_rvalid = rvld_out[0] & ~rst;
  assign b_rvalid = rvld_out[1] & ~rst;
  assign a_rdata  = rdat_out[0];
  assign b_rdata  = rdat_out[1];

endmodule
